// File: rtl/ebrick_ctrl_pkg.sv
// Shared constants for the EBRICK control block: UMI opcodes/error code, register map, sequencer states.
// Pure definitions; no latency or flow control of its own.
package ebrick_ctrl_pkg;

  localparam logic [4:0] UMI_REQ_READ   = 5'h01;
  localparam logic [4:0] UMI_RESP_READ  = 5'h02;
  localparam logic [4:0] UMI_REQ_WRITE  = 5'h03;
  localparam logic [4:0] UMI_RESP_WRITE = 5'h04;
  localparam logic [4:0] UMI_REQ_POSTED = 5'h05;
  localparam logic [1:0] UMI_ERR_DEV    = 2'b10;
  localparam logic [2:0] UMI_SIZE_32    = 3'd2;

  localparam logic [4:0] OFF_CTRL   = 5'h00;
  localparam logic [4:0] OFF_RSTCYC = 5'h04;
  localparam logic [4:0] OFF_GODLY  = 5'h08;
  localparam logic [4:0] OFF_STATE  = 5'h0C;
  localparam logic [4:0] OFF_STATUS = 5'h10;
  localparam logic [4:0] OFF_WDOG   = 5'h14;

  localparam int CTRL_START    = 0;
  localparam int CTRL_ABORT    = 1;
  localparam int CTRL_IRQEN    = 2;
  localparam int STATE_DONE    = 8;
  localparam int STATE_TIMEOUT = 9;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RST  = 2'd1,
    ST_WAIT = 2'd2,
    ST_RUN  = 2'd3
  } seq_state_t;

endpackage

// File: rtl/ebrick_ctrl_seq.sv
// Per-channel reset/go sequencer: IDLE -> RST (hold) -> WAIT (go delay) -> RUN; outputs decode directly from state.
// START/ABORT act at the accepting edge, no backpressure; EBRICK_CTRL_WDOG_EN adds the RUN watchdog.
module ebrick_ctrl_seq
  import ebrick_ctrl_pkg::*;
#(
  parameter int CNTW = 16
) (
  input  logic            clk,
  input  logic            reset,
`ifdef EBRICK_CTRL_WDOG_EN
  input  logic [CNTW-1:0] wdog,
  input  logic            clr_timeout,
`endif
  input  logic            start,
  input  logic            abort,
  input  logic            clr_done,
  input  logic [CNTW-1:0] rstcyc,
  input  logic [CNTW-1:0] godly,
  input  logic            status_bit,
  output logic [1:0]      state,
  output logic            done,
  output logic            timeout,
  output logic            nreset,
  output logic            go
);

  localparam logic [CNTW-1:0] CNT_ONE = CNTW'(1);

  seq_state_t      state_q, state_d;
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic [CNTW-1:0] godly_q, godly_d;
  logic            done_q, done_d;
  logic            status_q;
  logic            rise;

  assign rise = status_bit & ~status_q;

`ifdef EBRICK_CTRL_WDOG_EN
  logic [CNTW-1:0] wd_q, wd_d;
  logic            timeout_q, timeout_d;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    godly_d = godly_q;
    done_d  = done_q;
    if (clr_done) done_d = 1'b0;
`ifdef EBRICK_CTRL_WDOG_EN
    wd_d      = '0;
    timeout_d = timeout_q;
    if (clr_timeout) timeout_d = 1'b0;
`endif
    case (state_q)
      ST_RST: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_ONE;
        end else if (godly_q == '0) begin
          state_d = ST_RUN;
        end else begin
          state_d = ST_WAIT;
          cnt_d   = godly_q - CNT_ONE;
        end
      end
      ST_WAIT: begin
        if (cnt_q == '0) state_d = ST_RUN;
        else             cnt_d   = cnt_q - CNT_ONE;
      end
      ST_RUN: begin
        if (rise) done_d = 1'b1;
`ifdef EBRICK_CTRL_WDOG_EN
        // wd_d counts RUN cycles including the current one
        wd_d = (wd_q == '1) ? wd_q : wd_q + CNT_ONE;
        if (!done_q && !rise && (wdog != '0) && (wd_d >= wdog)) begin
          timeout_d = 1'b1;
          state_d   = ST_IDLE;
        end
`endif
      end
      default: ;
    endcase
    // Hold/delay lengths are captured here so later register writes wait for the next START.
    if (start) begin
      state_d = ST_RST;
      cnt_d   = (rstcyc == '0) ? '0 : rstcyc - CNT_ONE;
      godly_d = godly;
    end
    if (abort) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      godly_q  <= '0;
      done_q   <= 1'b0;
      status_q <= 1'b0;
`ifdef EBRICK_CTRL_WDOG_EN
      wd_q      <= '0;
      timeout_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      godly_q  <= godly_d;
      done_q   <= done_d;
      status_q <= status_bit;
`ifdef EBRICK_CTRL_WDOG_EN
      wd_q      <= wd_d;
      timeout_q <= timeout_d;
`endif
    end
  end

`ifdef EBRICK_CTRL_WDOG_EN
  assign timeout = timeout_q;
`else
  assign timeout = 1'b0;
`endif

  assign state  = state_q;
  assign done   = done_q;
  assign nreset = (state_q == ST_WAIT) || (state_q == ST_RUN);
  assign go     = (state_q == ST_RUN);

endmodule

// File: rtl/ebrick_ctrl_regs.sv
// UMI register block sequencing nreset/go for NCH EBRICK channels; reads/writes answer the cycle after acceptance.
// Single-entry response buffer: req_ready = !resp_valid | resp_ready (low in reset); EBRICK_CTRL_WDOG_EN maps WDOG at 0x14.
module ebrick_ctrl_regs
  import ebrick_ctrl_pkg::*;
#(
  parameter int NCH     = 4,
  parameter int DW      = 32,
  parameter int AW      = 64,
  parameter int CW      = 32,
  parameter int RW      = 32,
  parameter int CNTW    = 16,
  parameter int RST_DEF = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              udev_req_valid,
  input  logic [CW-1:0]     udev_req_cmd,
  input  logic [AW-1:0]     udev_req_dstaddr,
  input  logic [AW-1:0]     udev_req_srcaddr,
  input  logic [DW-1:0]     udev_req_data,
  output logic              udev_req_ready,
  output logic              udev_resp_valid,
  output logic [CW-1:0]     udev_resp_cmd,
  output logic [AW-1:0]     udev_resp_dstaddr,
  output logic [AW-1:0]     udev_resp_srcaddr,
  output logic [DW-1:0]     udev_resp_data,
  input  logic              udev_resp_ready,
  input  logic [NCH*RW-1:0] status_in,
  output logic [NCH-1:0]    chan_nreset,
  output logic [NCH-1:0]    chan_go,
  output logic              irq
);

  logic [4:0] req_op, off;
  logic [2:0] req_size;
  logic [7:0] req_len;
  logic [3:0] ch;
  logic       off_ok, addr_ok, accept, is_rd, is_wr, is_post, do_wr, do_resp;

  assign req_op   = udev_req_cmd[4:0];
  assign req_size = udev_req_cmd[7:5];
  assign req_len  = udev_req_cmd[15:8];
  assign ch       = udev_req_dstaddr[8:5];
  assign off      = udev_req_dstaddr[4:0];

  always_comb begin
    off_ok = 1'b0;
    case (off)
      OFF_CTRL, OFF_RSTCYC, OFF_GODLY, OFF_STATE, OFF_STATUS: off_ok = 1'b1;
`ifdef EBRICK_CTRL_WDOG_EN
      OFF_WDOG: off_ok = 1'b1;
`endif
      default: off_ok = 1'b0;
    endcase
  end

  assign addr_ok = off_ok && (int'(ch) < NCH) && (req_size == UMI_SIZE_32) && (req_len == 8'd0);

  logic           resp_valid_q;
  logic [CW-1:0]  resp_cmd_q, resp_cmd_d;
  logic [AW-1:0]  resp_dst_q, resp_src_q;
  logic [DW-1:0]  resp_data_q, rd_data;

  assign udev_req_ready = !reset && (!resp_valid_q || udev_resp_ready);
  assign accept  = udev_req_valid && udev_req_ready;
  assign is_rd   = (req_op == UMI_REQ_READ);
  assign is_wr   = (req_op == UMI_REQ_WRITE);
  assign is_post = (req_op == UMI_REQ_POSTED);
  assign do_wr   = accept && addr_ok && (is_wr || is_post);
  assign do_resp = accept && (is_rd || is_wr);

  logic [CNTW-1:0] rstcyc_q [NCH];
  logic [CNTW-1:0] godly_q  [NCH];
  logic [NCH-1:0]  irqen_q;
  logic [1:0]      state_w  [NCH];
  logic [NCH-1:0]  done_w, timeout_w;
`ifdef EBRICK_CTRL_WDOG_EN
  logic [CNTW-1:0] wdog_q   [NCH];
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      irqen_q <= '0;
      for (int i = 0; i < NCH; i++) begin
        rstcyc_q[i] <= CNTW'(RST_DEF);
        godly_q[i]  <= '0;
`ifdef EBRICK_CTRL_WDOG_EN
        wdog_q[i]   <= '0;
`endif
      end
    end else if (do_wr) begin
      for (int i = 0; i < NCH; i++) begin
        if (ch == 4'(i)) begin
          case (off)
            OFF_CTRL:   irqen_q[i]  <= udev_req_data[CTRL_IRQEN];
            OFF_RSTCYC: rstcyc_q[i] <= udev_req_data[CNTW-1:0];
            OFF_GODLY:  godly_q[i]  <= udev_req_data[CNTW-1:0];
`ifdef EBRICK_CTRL_WDOG_EN
            OFF_WDOG:   wdog_q[i]   <= udev_req_data[CNTW-1:0];
`endif
            default: ;
          endcase
        end
      end
    end
  end

  always_comb begin
    rd_data = '0;
    for (int i = 0; i < NCH; i++) begin
      if (ch == 4'(i)) begin
        case (off)
          OFF_CTRL:   rd_data[CTRL_IRQEN] = irqen_q[i];
          OFF_RSTCYC: rd_data = DW'(rstcyc_q[i]);
          OFF_GODLY:  rd_data = DW'(godly_q[i]);
          OFF_STATE: begin
            rd_data[1:0]          = state_w[i];
            rd_data[STATE_DONE]    = done_w[i];
            rd_data[STATE_TIMEOUT] = timeout_w[i];
          end
          OFF_STATUS: rd_data = DW'(status_in[i*RW +: RW]);
`ifdef EBRICK_CTRL_WDOG_EN
          OFF_WDOG:   rd_data = DW'(wdog_q[i]);
`endif
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    resp_cmd_d        = udev_req_cmd;
    resp_cmd_d[4:0]   = is_rd ? UMI_RESP_READ : UMI_RESP_WRITE;
    resp_cmd_d[25:24] = addr_ok ? 2'b00 : UMI_ERR_DEV;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      resp_valid_q <= 1'b0;
      resp_cmd_q   <= '0;
      resp_dst_q   <= '0;
      resp_src_q   <= '0;
      resp_data_q  <= '0;
    end else if (do_resp) begin
      resp_valid_q <= 1'b1;
      resp_cmd_q   <= resp_cmd_d;
      resp_dst_q   <= udev_req_srcaddr;
      resp_src_q   <= udev_req_dstaddr;
      resp_data_q  <= (is_rd && addr_ok) ? rd_data : '0;
    end else if (udev_resp_ready) begin
      resp_valid_q <= 1'b0;
    end
  end

  assign udev_resp_valid   = resp_valid_q;
  assign udev_resp_cmd     = resp_cmd_q;
  assign udev_resp_dstaddr = resp_dst_q;
  assign udev_resp_srcaddr = resp_src_q;
  assign udev_resp_data    = resp_data_q;

  for (genvar g = 0; g < NCH; g++) begin : g_ch
    logic wr_ch, wr_ctrl, wr_state;
    assign wr_ch    = do_wr && (ch == 4'(g));
    assign wr_ctrl  = wr_ch && (off == OFF_CTRL);
    assign wr_state = wr_ch && (off == OFF_STATE);

    ebrick_ctrl_seq #(.CNTW(CNTW)) u_seq (
      .clk         (clk),
      .reset       (reset),
`ifdef EBRICK_CTRL_WDOG_EN
      .wdog        (wdog_q[g]),
      .clr_timeout (wr_state && udev_req_data[STATE_TIMEOUT]),
`endif
      .start       (wr_ctrl && udev_req_data[CTRL_START]),
      .abort       (wr_ctrl && udev_req_data[CTRL_ABORT]),
      .clr_done    (wr_state && udev_req_data[STATE_DONE]),
      .rstcyc      (rstcyc_q[g]),
      .godly       (godly_q[g]),
      .status_bit  (status_in[g*RW]),
      .state       (state_w[g]),
      .done        (done_w[g]),
      .timeout     (timeout_w[g]),
      .nreset      (chan_nreset[g]),
      .go          (chan_go[g])
    );
  end

  assign irq = |(irqen_q & (done_w | timeout_w));

  // Address bits above the channel field and data bits above the counter width carry no meaning here.
  logic unused_bits;
  assign unused_bits = ^{udev_req_dstaddr[AW-1:9], udev_req_data[DW-1:CNTW]};

endmodule

// File: tb/tb_ebrick_ctrl_regs.sv
// Directed bench for ebrick_ctrl_regs: UMI reads/writes, channel sequencing, backpressure, error responses.
module tb_ebrick_ctrl_regs;

  localparam logic [4:0]  RD   = 5'h01;
  localparam logic [4:0]  WR   = 5'h03;
  localparam logic [4:0]  PO   = 5'h05;
  localparam logic [4:0]  RRD  = 5'h02;
  localparam logic [4:0]  RWR  = 5'h04;
  localparam logic [63:0] SRC  = 64'h1234_5678_9ABC_DEF0;

  logic         clk = 1'b0;
  logic         reset;
  logic         udev_req_valid;
  logic [31:0]  udev_req_cmd;
  logic [63:0]  udev_req_dstaddr;
  logic [63:0]  udev_req_srcaddr;
  logic [31:0]  udev_req_data;
  logic         udev_req_ready;
  logic         udev_resp_valid;
  logic [31:0]  udev_resp_cmd;
  logic [63:0]  udev_resp_dstaddr;
  logic [63:0]  udev_resp_srcaddr;
  logic [31:0]  udev_resp_data;
  logic         udev_resp_ready;
  logic [127:0] status_in;
  logic [3:0]   chan_nreset;
  logic [3:0]   chan_go;
  logic         irq;

  int n_checks = 0;
  int n_err    = 0;

  logic [3:0] exp_nr [6] = '{4'b0000, 4'b0000, 4'b0000, 4'b0010, 4'b0010, 4'b0010};
  logic [3:0] exp_go [6] = '{4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0010};

  ebrick_ctrl_regs dut (
    .clk               (clk),
    .reset             (reset),
    .udev_req_valid    (udev_req_valid),
    .udev_req_cmd      (udev_req_cmd),
    .udev_req_dstaddr  (udev_req_dstaddr),
    .udev_req_srcaddr  (udev_req_srcaddr),
    .udev_req_data     (udev_req_data),
    .udev_req_ready    (udev_req_ready),
    .udev_resp_valid   (udev_resp_valid),
    .udev_resp_cmd     (udev_resp_cmd),
    .udev_resp_dstaddr (udev_resp_dstaddr),
    .udev_resp_srcaddr (udev_resp_srcaddr),
    .udev_resp_data    (udev_resp_data),
    .udev_resp_ready   (udev_resp_ready),
    .status_in         (status_in),
    .chan_nreset       (chan_nreset),
    .chan_go           (chan_go),
    .irq               (irq)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One request, accepted at the next edge; returns #1 after that edge.
  task automatic req(input logic [4:0] op, input logic [63:0] addr, input logic [31:0] wdata,
                     input logic [2:0] size = 3'd2);
    udev_req_valid   = 1'b1;
    udev_req_cmd     = {16'h0000, 8'h00, size, op};
    udev_req_dstaddr = addr;
    udev_req_srcaddr = SRC;
    udev_req_data    = wdata;
    tick();
    udev_req_valid   = 1'b0;
  endtask

  task automatic chk_resp(input string tag, input logic [4:0] op, input logic [1:0] err,
                          input logic [2:0] size, input logic [31:0] d);
    chk({tag, "_vld"}, udev_resp_valid, 1);
    chk({tag, "_cmd"}, udev_resp_cmd, {6'd0, err, 16'd0, size, op});
    chk({tag, "_dat"}, udev_resp_data, d);
  endtask

  initial begin
    reset            = 1'b1;
    udev_req_valid   = 1'b0;
    udev_req_cmd     = '0;
    udev_req_dstaddr = '0;
    udev_req_srcaddr = '0;
    udev_req_data    = '0;
    udev_resp_ready  = 1'b1;
    status_in        = '0;
    repeat (3) tick();
    chk("rst_req_rdy", udev_req_ready, 0);
    chk("rst_resp_vld", udev_resp_valid, 0);
    reset = 1'b0;
    #1;
    chk("rst_nreset", chan_nreset, 0);
    chk("rst_go", chan_go, 0);
    chk("rst_irq", irq, 0);
    chk("rel_req_rdy", udev_req_ready, 1);

    // Reset values and address swap
    req(RD, 64'h04, 0);
    chk_resp("rd_rstcyc0", RRD, 2'b00, 3'd2, 32'd16);
    chk("rd_dst", udev_resp_dstaddr, SRC);
    chk("rd_src", udev_resp_srcaddr, 64'h04);
    req(RD, 64'h0C, 0);
    chk_resp("rd_state0", RRD, 2'b00, 3'd2, 32'h0);

    // ch1: RSTCYC=3, GODLY=2, START
    req(PO, 64'h24, 3);
    chk("po_noresp", udev_resp_valid, 0);
    req(PO, 64'h28, 2);
    req(PO, 64'h20, 1);
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("seq_nr%0d", i), chan_nreset, exp_nr[i]);
      chk($sformatf("seq_go%0d", i), chan_go, exp_go[i]);
      tick();
    end
    req(RD, 64'h2C, 0);
    chk_resp("rd_state1", RRD, 2'b00, 3'd2, 32'h3);
    tick();

    // Backpressure with a second read pending
    udev_resp_ready = 1'b0;
    req(RD, 64'h24, 0);
    chk_resp("bp_first", RRD, 2'b00, 3'd2, 32'd3);
    udev_req_valid   = 1'b1;
    udev_req_cmd     = {16'h0000, 8'h00, 3'd2, RD};
    udev_req_dstaddr = 64'h28;
    #1;
    chk("bp_rdy_low", udev_req_ready, 0);
    tick();
    tick();
    chk_resp("bp_hold", RRD, 2'b00, 3'd2, 32'd3);
    chk("bp_rdy_still", udev_req_ready, 0);
    udev_resp_ready = 1'b1;
    tick();
    udev_req_valid = 1'b0;
    chk_resp("bp_second", RRD, 2'b00, 3'd2, 32'd2);
    tick();
    chk("bp_drained", udev_resp_valid, 0);

    // DONE flag and irq on ch1
    req(PO, 64'h20, 4);
    chk("irq_pre", irq, 0);
    status_in[32] = 1'b1;
    tick();
    chk("irq_done", irq, 1);
    req(RD, 64'h2C, 0);
    chk_resp("rd_done", RRD, 2'b00, 3'd2, 32'h103);
    req(RD, 64'h30, 0);
    chk_resp("rd_status", RRD, 2'b00, 3'd2, 32'h1);
    req(WR, 64'h2C, 32'h100);
    chk_resp("w1c_done", RWR, 2'b00, 3'd2, 32'h0);
    chk("irq_cleared", irq, 0);
    chk("ch1_run_go", chan_go, 4'b0010);

    // Error responses and dropped posted writes
    req(RD, 64'h84, 0);
    chk_resp("bad_ch", RRD, 2'b10, 3'd2, 32'h0);
    req(RD, 64'h04, 0, 3'd0);
    chk_resp("bad_size", RRD, 2'b10, 3'd0, 32'h0);
    req(WR, 64'h18, 5);
    chk_resp("bad_off", RWR, 2'b10, 3'd2, 32'h0);
    req(PO, 64'h04, 7, 3'd0);
    chk("po_bad_noresp", udev_resp_valid, 0);
    req(PO, 64'h80, 1);
    chk("po_bad_ch_nr", chan_nreset, 4'b0010);
    req(RD, 64'h04, 0);
    chk_resp("rstcyc_kept", RRD, 2'b00, 3'd2, 32'd16);

    // ch2: ABORT in WAIT, then START+ABORT together
    req(PO, 64'h44, 1);
    req(PO, 64'h48, 5);
    req(PO, 64'h40, 1);
    tick();
    chk("wait_nr", chan_nreset, 4'b0110);
    chk("wait_go", chan_go, 4'b0010);
    req(PO, 64'h40, 2);
    chk("abort_nr", chan_nreset, 4'b0010);
    chk("abort_go", chan_go, 4'b0010);
    req(RD, 64'h4C, 0);
    chk_resp("abort_state", RRD, 2'b00, 3'd2, 32'h0);
    req(PO, 64'h40, 1);
    req(PO, 64'h40, 3);
    tick();
    chk("sa_nr", chan_nreset, 4'b0010);
    req(RD, 64'h4C, 0);
    chk_resp("sa_state", RRD, 2'b00, 3'd2, 32'h0);

    // START while RUN restarts ch1 at RST
    req(PO, 64'h20, 5);
    chk("restart_nr", chan_nreset, 4'b0000);
    chk("restart_go", chan_go, 4'b0000);

`ifdef EBRICK_CTRL_WDOG_EN
    // ch3 watchdog: RUN for exactly 10 cycles, then TIMEOUT
    req(PO, 64'h64, 1);
    req(PO, 64'h74, 10);
    req(PO, 64'h60, 5);
    for (int i = 1; i <= 10; i++) begin
      tick();
      chk($sformatf("wd_go%0d", i), chan_go[3], 1);
    end
    tick();
    chk("wd_go_drop", chan_go[3], 0);
    chk("wd_nr_drop", chan_nreset[3], 0);
    chk("wd_irq", irq, 1);
    req(RD, 64'h6C, 0);
    chk_resp("wd_state", RRD, 2'b00, 3'd2, 32'h200);
    req(WR, 64'h6C, 32'h200);
    chk_resp("wd_w1c", RWR, 2'b00, 3'd2, 32'h0);
    chk("wd_irq_clr", irq, 0);
`else
    req(RD, 64'h34, 0);
    chk_resp("wdog_unmapped", RRD, 2'b10, 3'd2, 32'h0);
    req(RD, 64'h2C, 0);
    chk("no_timeout_bit", udev_resp_data[9], 0);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
